// File: rtl/uart_pkg.sv
// uart_pkg: bit timing and state types shared by the UART receiver and transmitter
package uart_pkg;
    localparam int unsigned BAUD_CNT = 2604;
    localparam int unsigned HALF_CNT = 1302;
    typedef enum logic {IDLE, RECEIVE} rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery handshake between the receiver and its consumer
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       clr_rdy;
    modport master (output rx_data, rdy, frm_err, input clr_rdy);
    modport slave (input rx_data, rdy, frm_err, output clr_rdy);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer, preset high so an idle-high line shows no edge at reset release
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with false-start rejection, stop-bit check and an SR ready flag
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD = BAUD_CNT,
    parameter int unsigned HALF = HALF_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    uart_rx_if.master rx_if
);
    localparam logic [11:0] RELOAD = 12'(BAUD - 1);
    localparam logic [11:0] HALF_LD = 12'(HALF);
    rx_state_t   state_q, state_d;
    logic        rx_s, rx_prev_q;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d, ferr_q, ferr_d;
    logic        start, sample, abort, done;
    uart_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d_i(RX), .q_o(rx_s));
    // A start needs a falling edge, so a held-low line cannot re-trigger
    assign start  = (state_q == IDLE) & rx_prev_q & ~rx_s;
    assign sample = (state_q == RECEIVE) & (baud_cnt_q == 12'd0);
    assign abort  = sample & (bit_cnt_q == 4'd0) & rx_s;
    assign done   = (state_q == RECEIVE) & (bit_cnt_q == 4'd10);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    always_comb begin
        state_d = state_q;
        state_d = start ? RECEIVE : (abort | done) ? IDLE : state_q;
    end
    always_comb begin
        baud_cnt_d = start ? HALF_LD : sample ? RELOAD :
                     (state_q == RECEIVE) ? baud_cnt_q - 12'd1 : baud_cnt_q;
        bit_cnt_d  = start ? 4'd0 : sample ? bit_cnt_q + 4'd1 : bit_cnt_q;
        shift_d    = sample ? {rx_s, shift_q[8:1]} : shift_q;
        data_d     = done ? shift_q[7:0] : data_q;
        ferr_d     = done ? ~shift_q[8] : ferr_q;
        rdy_d      = done | (rdy_q & ~rx_if.clr_rdy & ~start);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_prev_q  <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            rx_prev_q  <= rx_s;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            ferr_q     <= ferr_d;
            rdy_q      <= rdy_d;
        end
    assign rx_if.rx_data = data_q;
    assign rx_if.rdy     = rdy_q;
    assign rx_if.frm_err = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a bit-level reference transmitter and byte scoreboard
module tb_uart_rx;
    import uart_pkg::*;
    localparam int B = 32;
    localparam int H = 16;
    localparam int LAT_MIN = 9 * B + H;
    localparam int LAT_MAX = 9 * B + H + 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int lat0 = -1;
    logic [7:0] exp_q[$];
    uart_rx_if bus ();
    uart_rx #(.BAUD(B), .HALF(H)) dut (.clk(clk), .rst_n(rst_n), .RX(rx_line), .rx_if(bus));
    always #5 clk = ~clk;

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (B) @(negedge clk);
        end
    endtask

    // Sends one frame while counting rdy rising edges and the cycle of the first one
    task automatic run_frame(input logic [7:0] b, input logic stop, output int lat, output int rises);
        int l, r;
        l = -1;
        r = 0;
        fork
            send_frame(b, stop);
            begin
                logic p;
                p = bus.rdy;
                for (int i = 1; i <= 10 * B; i++) begin
                    @(negedge clk);
                    if (bus.rdy && !p) begin
                        r++;
                        if (l < 0) l = i;
                    end
                    p = bus.rdy;
                end
            end
        join
        lat = l;
        rises = r;
    endtask

    task automatic test_reset();
        bus.clr_rdy = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b want 0", bus.rdy); end
        n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.rx_data); end
        n_cmp++; if (bus.frm_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", bus.frm_err); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL release_rdy got %b want 0", bus.rdy); end
    endtask

    task automatic test_normal();
        int lat, rises;
        run_frame(8'hA5, 1'b1, lat, rises);
        lat0 = lat;
        n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL normal_rises got %0d want 1", rises); end
        n_cmp++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_err++; $display("FAIL normal_latency got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
        n_cmp++; if (bus.rx_data !== 8'hA5) begin n_err++; $display("FAIL normal_data got %h want a5", bus.rx_data); end
        n_cmp++; if (bus.frm_err !== 1'b0) begin n_err++; $display("FAIL normal_ferr got %b want 0", bus.frm_err); end
    endtask

    task automatic test_extremes();
        logic [7:0] pats [3];
        int lat, rises;
        pats = '{8'h00, 8'hFF, 8'h55};
        for (int k = 0; k < 3; k++) begin
            run_frame(pats[k], 1'b1, lat, rises);
            n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL ext_rises[%0d] got %0d want 1", k, rises); end
            n_cmp++; if (bus.rx_data !== pats[k]) begin n_err++; $display("FAIL ext_data[%0d] got %h want %h", k, bus.rx_data, pats[k]); end
            n_cmp++; if (bus.frm_err !== 1'b0) begin n_err++; $display("FAIL ext_ferr[%0d] got %b want 0", k, bus.frm_err); end
            bus.clr_rdy = 1'b1;
            @(negedge clk);
            bus.clr_rdy = 1'b0;
            n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL ext_clr[%0d] rdy got %b want 0", k, bus.rdy); end
        end
    endtask

    task automatic test_false_start();
        int lat, rises;
        logic p;
        rx_line = 1'b0;
        repeat (5) @(negedge clk);
        rx_line = 1'b1;
        repeat (H + 3) @(negedge clk);
        n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL false_idle state got %0d want IDLE", dut.state_q); end
        rises = 0;
        p = bus.rdy;
        for (int i = 0; i < 2 * B; i++) begin
            @(negedge clk);
            if (bus.rdy && !p) rises++;
            p = bus.rdy;
        end
        n_cmp++; if (rises !== 0) begin n_err++; $display("FAIL false_rdy rises got %0d want 0", rises); end
        run_frame(8'h3C, 1'b1, lat, rises);
        n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL after_false_rises got %0d want 1", rises); end
        n_cmp++; if (bus.rx_data !== 8'h3C) begin n_err++; $display("FAIL after_false_data got %h want 3c", bus.rx_data); end
    endtask

    task automatic test_framing();
        int lat, rises;
        run_frame(8'h81, 1'b0, lat, rises);
        rx_line = 1'b1;
        repeat (B) @(negedge clk);
        n_cmp++; if (bus.rdy !== 1'b1) begin n_err++; $display("FAIL ferr_rdy got %b want 1", bus.rdy); end
        n_cmp++; if (bus.rx_data !== 8'h81) begin n_err++; $display("FAIL ferr_data got %h want 81", bus.rx_data); end
        n_cmp++; if (bus.frm_err !== 1'b1) begin n_err++; $display("FAIL ferr_flag got %b want 1", bus.frm_err); end
        run_frame(8'h5A, 1'b1, lat, rises);
        n_cmp++; if (bus.frm_err !== 1'b0) begin n_err++; $display("FAIL ferr_clear got %b want 0", bus.frm_err); end
        n_cmp++; if (bus.rx_data !== 8'h5A) begin n_err++; $display("FAIL ferr_next_data got %h want 5a", bus.rx_data); end
    endtask

    task automatic test_break();
        int rises;
        logic p;
        rises = 0;
        p = bus.rdy;
        rx_line = 1'b0;
        for (int i = 0; i < 25 * B; i++) begin
            if (i == 15 * B) rx_line = 1'b1;
            @(negedge clk);
            if (bus.rdy && !p) rises++;
            p = bus.rdy;
        end
        n_cmp++; if (rises !== 1) begin n_err++; $display("FAIL break_rises got %0d want 1", rises); end
        n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL break_data got %h want 00", bus.rx_data); end
        n_cmp++; if (bus.frm_err !== 1'b1) begin n_err++; $display("FAIL break_ferr got %b want 1", bus.frm_err); end
    endtask

    task automatic test_back_to_back();
        int lat, rises, lr;
        logic [7:0] b, e;
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            run_frame(b, 1'b1, lat, rises);
            e = exp_q.pop_front();
            n_cmp++; if (rises !== 1 || bus.rx_data !== e) begin n_err++; $display("FAIL loop[%0d] data got %h rises %0d want %h rises 1", k, bus.rx_data, rises, e); end
        end
        // Acknowledge lands in the same cycle as completion; the set must win
        lr = (lat0 >= LAT_MIN && lat0 <= LAT_MAX) ? lat0 : LAT_MIN + 3;
        b = 8'($urandom_range(0, 255));
        fork
            send_frame(b, 1'b1);
            begin
                repeat (lr - 1) @(negedge clk);
                bus.clr_rdy = 1'b1;
                @(negedge clk);
                bus.clr_rdy = 1'b0;
                n_cmp++; if (bus.rdy !== 1'b1) begin n_err++; $display("FAIL set_wins rdy got %b want 1", bus.rdy); end
                @(negedge clk);
                n_cmp++; if (bus.rdy !== 1'b1 || bus.rx_data !== b) begin n_err++; $display("FAIL set_wins_hold rdy %b data %h want 1 %h", bus.rdy, bus.rx_data, b); end
            end
        join
    endtask

    task automatic test_reset_mid();
        int lat, rises;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (5 * B + B / 2) @(negedge clk);
                rst_n = 1'b0;
                #1;
                n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL midrst_rdy got %b want 0", bus.rdy); end
                n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want 00", bus.rx_data); end
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL midrst_nopartial rdy got %b want 0", bus.rdy); end
        run_frame(8'h7E, 1'b1, lat, rises);
        n_cmp++; if (rises !== 1 || bus.rx_data !== 8'h7E) begin n_err++; $display("FAIL midrst_next data %h rises %0d want 7e rises 1", bus.rx_data, rises); end
        n_cmp++; if (bus.frm_err !== 1'b0) begin n_err++; $display("FAIL midrst_next_ferr got %b want 0", bus.frm_err); end
    endtask

    initial begin
        bus.clr_rdy = 1'b0;
        test_reset();
        test_normal();
        test_extremes();
        test_false_start();
        test_framing();
        test_break();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1 format (1 start, 8 data LSB-first, 1 stop), 19200 baud from a 50 MHz clk.
- Pairs with the existing UART transmitter at the other end of the serial link; bit timing is identical.
- Delivers each byte on rx_data and flags it with rdy; the consumer acknowledges with clr_rdy.
- Checks the stop bit and rejects glitch starts.

Parameters:
- BAUD_CNT, 2604 (12'hA2C): clk cycles per bit.
- HALF_CNT, 1302: clk cycles from start-bit detection to the start-bit mid-sample.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- RX  input  1  serial line, asynchronous to clk, idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy.
- rx_data  output  8  received byte, stable while rdy=1.
- rdy  output  1  byte available.
- frm_err  output  1  stop bit of the last completed frame sampled 0.

Behaviour:
- Reset values: rx_data=8'h00, rdy=0, frm_err=0, state=IDLE, synchronizer flops=1 (preset, so no false start at reset release).
- Sync: RX passes through 2 flops to give rx_s. Edge detection and all sampling use rx_s only.
- Counters:
  - baud_cnt is 12-bit and counts down; sample fires when baud_cnt==0.
  - bit_cnt is 4-bit, counts samples 0..10.
- FSM, states IDLE and RECEIVE:
  - IDLE, rx_s==0: load baud_cnt=HALF_CNT, bit_cnt=0, clear rdy, go to RECEIVE.
  - IDLE, otherwise: hold.
  - RECEIVE, no sample: baud_cnt decrements each cycle.
  - RECEIVE, on sample: shift rx_s into a 9-bit shift register from the MSB end, bit_cnt++, reload baud_cnt=BAUD_CNT-1.
- Sample 1 (start bit): if rx_s==1, it is a false start. Abort to IDLE, no rdy, rx_data and frm_err unchanged.
- Sample 10 (stop bit):
  - Next edge: rx_data<=shift[7:0], frm_err<=~rx_s, rdy<=1, state<=IDLE.
  - rdy is set even on a framing error.
- Latency: rdy rises 1 clk after the stop-bit mid-sample. This is ~9.5 bit times plus 2 sync cycles after the RX falling edge.
- rdy handling:
  - rdy is an SR flop: set on frame completion; cleared by clr_rdy or by a new start detection.
  - Set and clr_rdy in the same cycle: set wins.
  - clr_rdy while rdy=0 has no effect.
- Back-to-back frames: a new start may be detected the cycle after returning to IDLE, including while rdy=1. rx_data holds the old byte until the new frame completes.
- Overrun: an unacknowledged byte is silently replaced at the next completion. No overrun flag.
- RX held low (break): a frame completes with data 8'h00 and frm_err=1. The FSM does not re-trigger until rx_s has been seen high, so it waits in IDLE for a high level.
- Reset mid-frame returns everything to reset values immediately, with no partial byte delivered.

Decomposition:
- Shared package uart_pkg holds:
  - BAUD_CNT and HALF_CNT, shared with the transmitter.
  - typedef enum rx_state_t {IDLE, RECEIVE}.
- Optional sub-module uart_sync2: 2-flop synchronizer with set-on-reset, reusable for other async inputs.
- The remaining logic stays flat in uart_rx.

Test Plan:
- Normal frame: drive byte 8'hA5 on RX at 2604 clk/bit with stop=1 -> rdy rises ~24740 clk after the start edge, rx_data=8'hA5, frm_err=0.
- Data extremes: frames 8'h00, then 8'hFF, then 8'h55 -> each delivered exactly, rdy once per frame; pulse clr_rdy between frames -> rdy=0 the next cycle.
- False start: RX low for 200 clk then high -> no rdy; FSM back in IDLE before 1400 clk; a following valid 8'h3C frame is still received correctly.
- Framing error: 8'h81 frame with stop bit 0, then RX returned high -> rdy=1, rx_data=8'h81, frm_err=1; next good frame clears frm_err to 0.
- Loopback: transmitter TX wired to RX, 16 random bytes sent back-to-back, consumer never clears rdy -> every byte matches the sent byte at its rdy edge; clr_rdy pulsed in the same cycle as completion -> rdy stays 1.
- Reset mid-frame: assert rst_n=0 at data bit 4 of 8'hC3 -> rdy=0, rx_data=8'h00 immediately; after release the next frame 8'h7E is received intact.
